// File: rtl/video_out_stage.sv
// VGA output stage: selects a display mode, blanks outside active video, and
// delays pixel and sync together by DELAY pixel ticks. Also counts frames.
module video_out_stage #(
  parameter int   COLOR_W   = 4,
  parameter int   DELAY     = 2,
  parameter int   H_ACTIVE  = 640,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic                   clk_100MHz,
  input  logic                   reset,
  input  logic                   p_tick,
  input  logic                   video_on,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  input  logic [1:0]             mode,
  output logic [3*COLOR_W-1:0]   rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   video_on_out,
  output logic                   frame_start,
  output logic [7:0]             frame_cnt
);

  localparam int RGB_W = 3 * COLOR_W;
  localparam int BAR_W = H_ACTIVE / 8;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_BARS   = 2'd1;
  localparam logic [1:0] MODE_SOLID  = 2'd2;
  localparam logic [1:0] MODE_INVERT = 2'd3;

  logic [1:0]       active_mode;
  logic [1:0]       sel_mode;
  logic             frame_hit;
  logic [31:0]      bar_idx;
  logic [2:0]       bar_bits;
  logic [RGB_W-1:0] bar_rgb;
  logic [RGB_W-1:0] sel_rgb;
  logic [RGB_W-1:0] pix;

  logic [RGB_W-1:0] rgb_s [DELAY];
  logic             vo_s  [DELAY];
  logic             hs_s  [DELAY];
  logic             vs_s  [DELAY];

  assign frame_hit = p_tick && (x == 10'd0) && (y == 10'd0);

  // The pixel at (0,0) already uses the mode being latched on that same edge.
  assign sel_mode = frame_hit ? mode : active_mode;

  assign bar_idx = {22'd0, x} / 32'(BAR_W);

  always_comb begin
    bar_bits = 3'b000;
    if ((32'(x) < 32'(H_ACTIVE)) && (bar_idx < 32'd8)) begin
      case (bar_idx[2:0])
        3'd0:    bar_bits = 3'b111;
        3'd1:    bar_bits = 3'b110;
        3'd2:    bar_bits = 3'b011;
        3'd3:    bar_bits = 3'b010;
        3'd4:    bar_bits = 3'b101;
        3'd5:    bar_bits = 3'b100;
        3'd6:    bar_bits = 3'b001;
        default: bar_bits = 3'b000;
      endcase
    end
  end

  assign bar_rgb = {{COLOR_W{bar_bits[2]}}, {COLOR_W{bar_bits[1]}}, {COLOR_W{bar_bits[0]}}};

  always_comb begin
    sel_rgb = rgb_in;
    case (sel_mode)
      MODE_PASS:   sel_rgb = rgb_in;
      MODE_BARS:   sel_rgb = bar_rgb;
      MODE_SOLID:  sel_rgb = solid_rgb;
      MODE_INVERT: sel_rgb = ~rgb_in;
      default:     sel_rgb = rgb_in;
    endcase
  end

  assign pix = video_on ? sel_rgb : '0;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      active_mode <= MODE_PASS;
      frame_cnt   <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_hit;
      if (frame_hit) begin
        active_mode <= mode;
        frame_cnt   <= frame_cnt + 8'd1;
      end
    end
  end

  // Pixel and sync share one shift chain so they can never drift apart.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      for (int i = 0; i < DELAY; i++) begin
        rgb_s[i] <= '0;
        vo_s[i]  <= 1'b0;
        hs_s[i]  <= SYNC_IDLE;
        vs_s[i]  <= SYNC_IDLE;
      end
    end else if (p_tick) begin
      rgb_s[0] <= pix;
      vo_s[0]  <= video_on;
      hs_s[0]  <= hsync_in;
      vs_s[0]  <= vsync_in;
      for (int i = 1; i < DELAY; i++) begin
        rgb_s[i] <= rgb_s[i-1];
        vo_s[i]  <= vo_s[i-1];
        hs_s[i]  <= hs_s[i-1];
        vs_s[i]  <= vs_s[i-1];
      end
    end
  end

  assign rgb          = rgb_s[DELAY-1];
  assign video_on_out = vo_s[DELAY-1];
  assign hsync        = hs_s[DELAY-1];
  assign vsync        = vs_s[DELAY-1];

endmodule

// File: tb/tb_video_out_stage.sv
// Testbench for video_out_stage: table vectors and hand sequences feed a
// scoreboard queue that is popped after every pixel tick.
module tb_video_out_stage;

  localparam int DELAY = 2;

  typedef struct {
    logic [1:0]  md;
    logic        vo;
    logic        hs;
    logic        vs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rin;
    logic [11:0] solid;
    logic [11:0] exp;
  } vec_t;

  typedef struct packed {
    logic [11:0] rgb;
    logic        vo;
    logic        hs;
    logic        vs;
  } out_t;

  logic        clk_100MHz;
  logic        reset;
  logic        p_tick;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] rgb_in;
  logic [11:0] solid_rgb;
  logic [1:0]  mode;
  logic [11:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        video_on_out;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  int   checks;
  int   errors;
  logic [7:0] model_cnt;
  out_t exp_q [$];
  vec_t vecs [12];

  video_out_stage #(
    .COLOR_W(4), .DELAY(DELAY), .H_ACTIVE(640), .SYNC_IDLE(1'b1)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .p_tick      (p_tick),
    .video_on    (video_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .x           (x),
    .y           (y),
    .rgb_in      (rgb_in),
    .solid_rgb   (solid_rgb),
    .mode        (mode),
    .rgb         (rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on_out(video_on_out),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_rgb"}, rgb, 12'h000);
    checkOutput({tag, "_video_on"}, {11'd0, video_on_out}, 12'd0);
    checkOutput({tag, "_hsync"}, {11'd0, hsync}, 12'd1);
    checkOutput({tag, "_vsync"}, {11'd0, vsync}, 12'd1);
    checkOutput({tag, "_frame_cnt"}, {4'd0, frame_cnt}, 12'd0);
    checkOutput({tag, "_frame_start"}, {11'd0, frame_start}, 12'd0);
  endtask

  // Model state after any reset: the final stage shows idle values for DELAY-1 ticks.
  task automatic prefillQueue();
    out_t idle;
    exp_q.delete();
    idle.rgb = 12'h000;
    idle.vo  = 1'b0;
    idle.hs  = 1'b1;
    idle.vs  = 1'b1;
    for (int i = 0; i < DELAY - 1; i++) exp_q.push_back(idle);
    model_cnt = 8'd0;
  endtask

  task automatic resetDut();
    @(negedge clk_100MHz);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_tick = i[0] ? 1'b0 : 1'b1;
      @(posedge clk_100MHz);
      #1;
      @(negedge clk_100MHz);
    end
    checkIdle("reset");
    reset  = 1'b0;
    p_tick = 1'b0;
    prefillQueue();
  endtask

  task automatic applyStimulus(input vec_t v);
    out_t e;
    out_t got;
    logic fs;
    @(negedge clk_100MHz);
    mode      = v.md;
    video_on  = v.vo;
    hsync_in  = v.hs;
    vsync_in  = v.vs;
    x         = v.x;
    y         = v.y;
    rgb_in    = v.rin;
    solid_rgb = v.solid;
    p_tick    = 1'b1;
    e.rgb = v.exp;
    e.vo  = v.vo;
    e.hs  = v.hs;
    e.vs  = v.vs;
    exp_q.push_back(e);
    fs = (v.x == 10'd0) && (v.y == 10'd0);
    if (fs) model_cnt = model_cnt + 8'd1;
    @(posedge clk_100MHz);
    #1;
    got = exp_q.pop_front();
    checkOutput("rgb", rgb, got.rgb);
    checkOutput("video_on_out", {11'd0, video_on_out}, {11'd0, got.vo});
    checkOutput("hsync", {11'd0, hsync}, {11'd0, got.hs});
    checkOutput("vsync", {11'd0, vsync}, {11'd0, got.vs});
    checkOutput("frame_start", {11'd0, frame_start}, {11'd0, fs});
    checkOutput("frame_cnt", {4'd0, frame_cnt}, {4'd0, model_cnt});
    // Idle cycle: scramble inputs, including a (0,0) position, with p_tick low.
    @(negedge clk_100MHz);
    p_tick   = 1'b0;
    x        = 10'd0;
    y        = 10'd0;
    rgb_in   = 12'($urandom);
    mode     = 2'($urandom);
    video_on = 1'($urandom);
    hsync_in = 1'($urandom);
    @(posedge clk_100MHz);
    #1;
    checkOutput("rgb_hold", rgb, got.rgb);
    checkOutput("hsync_hold", {11'd0, hsync}, {11'd0, got.hs});
    checkOutput("frame_start_pulse", {11'd0, frame_start}, 12'd0);
    checkOutput("frame_cnt_hold", {4'd0, frame_cnt}, {4'd0, model_cnt});
  endtask

  function automatic logic [11:0] barColour(input int px);
    if (px >= 640)      return 12'h000;
    else if (px < 80)   return 12'hFFF;
    else if (px < 160)  return 12'hFF0;
    else if (px < 240)  return 12'h0FF;
    else if (px < 320)  return 12'h0F0;
    else if (px < 400)  return 12'hF0F;
    else if (px < 480)  return 12'hF00;
    else if (px < 560)  return 12'h00F;
    else                return 12'h000;
  endfunction

  initial begin
    vec_t v;
    checks    = 0;
    errors    = 0;
    model_cnt = 8'd0;
    reset     = 1'b1;
    p_tick    = 1'b0;
    video_on  = 1'b0;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    x         = 10'd5;
    y         = 10'd5;
    rgb_in    = 12'h000;
    solid_rgb = 12'h000;
    mode      = 2'd0;

    //             md    vo    hs    vs    x       y       rin      solid    exp
    vecs[0]  = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd5,  10'd3,  12'hABC, 12'h000, 12'hABC};
    vecs[1]  = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd6,  10'd3,  12'h000, 12'h000, 12'h000};
    vecs[2]  = '{2'd0, 1'b0, 1'b1, 1'b1, 10'd7,  10'd3,  12'hFFF, 12'h000, 12'h000};
    vecs[3]  = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd8,  10'd3,  12'hFFF, 12'h000, 12'hFFF};
    vecs[4]  = '{2'd0, 1'b0, 1'b0, 1'b1, 10'd9,  10'd3,  12'h123, 12'h000, 12'h000};
    vecs[5]  = '{2'd3, 1'b1, 1'b1, 1'b0, 10'd10, 10'd3,  12'h0F0, 12'h000, 12'h0F0};
    vecs[6]  = '{2'd3, 1'b1, 1'b1, 1'b1, 10'd0,  10'd0,  12'h0F0, 12'h000, 12'hF0F};
    vecs[7]  = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd1,  10'd0,  12'h0F0, 12'h000, 12'hF0F};
    vecs[8]  = '{2'd2, 1'b1, 1'b1, 1'b1, 10'd2,  10'd0,  12'h111, 12'h5A5, 12'hEEE};
    vecs[9]  = '{2'd2, 1'b1, 1'b1, 1'b1, 10'd0,  10'd0,  12'h111, 12'h5A5, 12'h5A5};
    vecs[10] = '{2'd1, 1'b1, 1'b1, 1'b1, 10'd1,  10'd0,  12'h111, 12'h5A5, 12'h5A5};
    vecs[11] = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd0,  10'd0,  12'h321, 12'h5A5, 12'h321};

    resetDut();
    $display("[TB] table vectors");
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    $display("[TB] colour bar sweep");
    for (int px = 0; px < 800; px++) begin
      v.md    = 2'd1;
      v.vo    = (px < 640);
      v.hs    = 1'b1;
      v.vs    = 1'b1;
      v.x     = 10'(px);
      v.y     = 10'd0;
      v.rin   = 12'h5A5;
      v.solid = 12'h000;
      v.exp   = (px < 640) ? barColour(px) : 12'h000;
      applyStimulus(v);
    end

    $display("[TB] reset mid-operation");
    v = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 12'h000, 12'h000, 12'h000};
    applyStimulus(v);
    v = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 12'h123, 12'h000, 12'h123};
    applyStimulus(v);
    @(negedge clk_100MHz);
    reset  = 1'b1;
    p_tick = 1'b1;
    x      = 10'd2;
    y      = 10'd0;
    @(posedge clk_100MHz);
    #1;
    checkIdle("reset_mid");
    @(negedge clk_100MHz);
    reset  = 1'b0;
    p_tick = 1'b0;
    prefillQueue();
    v = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd5, 10'd5, 12'h456, 12'h000, 12'h456};
    applyStimulus(v);
    v = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd6, 10'd5, 12'h000, 12'h000, 12'h000};
    applyStimulus(v);

    $display("[TB] 256 frame wrap");
    resetDut();
    for (int f = 0; f < 256; f++) begin
      v = '{2'd0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 12'(f), 12'h000, 12'(f)};
      applyStimulus(v);
    end
    checkOutput("frame_wrap", {4'd0, frame_cnt}, 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
